// File: rtl/bsg_axil_rw_serializer_pkg.sv
// Shared AXI-Lite definitions.
//
// Holds the read/write serializer FSM state encoding so that sibling
// AXI-Lite blocks can reuse it, plus the bit positions of the
// write-handshake completion flags.
package bsg_axil_rw_serializer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_RESP = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4
    } bsg_axil_rw_ser_state_e;

    // Bit positions inside the 2-bit "channel done" flag register used
    // while a write is in progress.
    localparam int unsigned DONE_AW = 1;
    localparam int unsigned DONE_W  = 0;

endpackage

// File: rtl/bsg_axil_rw_serializer_dff.sv
// bsg_dff_reset_set_clear
//
// Register bank where each bit can be individually set or cleared.
// Set wins over clear when both hit the same bit in the same cycle.
//
// Ports:
//   clk_i    - clock
//   reset_i  - synchronous active-high reset, forces all bits to 0
//   set_i    - per-bit set request
//   clear_i  - per-bit clear request
//   data_o   - current register contents
module bsg_dff_reset_set_clear #(
    parameter int width_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] set_i,
    input  logic [width_p-1:0] clear_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_q;
    logic [width_p-1:0] data_d;

    always_comb begin
        data_d = (data_q & ~clear_i) | set_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bsg_axil_rw_serializer.sv
// bsg_axil_rw_serializer
//
// Turns an AXI4-Lite slave port that may carry concurrent reads and
// writes into a master port with at most one transaction outstanding
// and with arvalid/awvalid never asserted together. Read vs. write is
// arbitrated round-robin; once a transaction is granted its channels
// are passed straight through with no added latency.
//
// Ports:
//   clk_i, reset_i     - clock, synchronous active-high reset
//   s00_axil_aw/w/b/ar/r - upstream slave port (from the requester)
//   m00_axil_aw/w/b/ar/r - downstream master port (toward the demux)
module bsg_axil_rw_serializer
    import bsg_axil_rw_serializer_pkg::*;
#(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_i,

    input  logic [addr_width_p-1:0]   s00_axil_awaddr,
    input  logic [2:0]                s00_axil_awprot,
    input  logic                      s00_axil_awvalid,
    output logic                      s00_axil_awready,
    input  logic [data_width_p-1:0]   s00_axil_wdata,
    input  logic [data_width_p/8-1:0] s00_axil_wstrb,
    input  logic                      s00_axil_wvalid,
    output logic                      s00_axil_wready,
    output logic [1:0]                s00_axil_bresp,
    output logic                      s00_axil_bvalid,
    input  logic                      s00_axil_bready,
    input  logic [addr_width_p-1:0]   s00_axil_araddr,
    input  logic [2:0]                s00_axil_arprot,
    input  logic                      s00_axil_arvalid,
    output logic                      s00_axil_arready,
    output logic [data_width_p-1:0]   s00_axil_rdata,
    output logic [1:0]                s00_axil_rresp,
    output logic                      s00_axil_rvalid,
    input  logic                      s00_axil_rready,

    output logic [addr_width_p-1:0]   m00_axil_awaddr,
    output logic [2:0]                m00_axil_awprot,
    output logic                      m00_axil_awvalid,
    input  logic                      m00_axil_awready,
    output logic [data_width_p-1:0]   m00_axil_wdata,
    output logic [data_width_p/8-1:0] m00_axil_wstrb,
    output logic                      m00_axil_wvalid,
    input  logic                      m00_axil_wready,
    input  logic [1:0]                m00_axil_bresp,
    input  logic                      m00_axil_bvalid,
    output logic                      m00_axil_bready,
    output logic [addr_width_p-1:0]   m00_axil_araddr,
    output logic [2:0]                m00_axil_arprot,
    output logic                      m00_axil_arvalid,
    input  logic                      m00_axil_arready,
    input  logic [data_width_p-1:0]   m00_axil_rdata,
    input  logic [1:0]                m00_axil_rresp,
    input  logic                      m00_axil_rvalid,
    output logic                      m00_axil_rready
);

    bsg_axil_rw_ser_state_e state_q, state_d;
    logic                   last_write_q, last_write_d;

    logic [1:0] done_q;
    logic [1:0] done_set;
    logic [1:0] done_clear;

    logic aw_go, w_go;
    logic aw_hs, w_hs;

    // aw/w completion flags for the write in flight; cleared when a
    // write is granted, set on each channel's handshake.
    bsg_dff_reset_set_clear #(.width_p(2)) done_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .set_i   (done_set),
        .clear_i (done_clear),
        .data_o  (done_q)
    );

    // Payload fields are never gated: only the valid/ready pairs decide
    // whether a beat is transferred.
    assign m00_axil_awaddr = s00_axil_awaddr;
    assign m00_axil_awprot = s00_axil_awprot;
    assign m00_axil_wdata  = s00_axil_wdata;
    assign m00_axil_wstrb  = s00_axil_wstrb;
    assign m00_axil_araddr = s00_axil_araddr;
    assign m00_axil_arprot = s00_axil_arprot;
    assign s00_axil_bresp  = m00_axil_bresp;
    assign s00_axil_rdata  = m00_axil_rdata;
    assign s00_axil_rresp  = m00_axil_rresp;

    always_comb begin
        state_d      = state_q;
        last_write_d = last_write_q;
        done_set     = '0;
        done_clear   = '0;
        aw_go        = 1'b0;
        w_go         = 1'b0;
        aw_hs        = 1'b0;
        w_hs         = 1'b0;

        m00_axil_awvalid = 1'b0;
        m00_axil_wvalid  = 1'b0;
        m00_axil_bready  = 1'b0;
        m00_axil_arvalid = 1'b0;
        m00_axil_rready  = 1'b0;
        s00_axil_awready = 1'b0;
        s00_axil_wready  = 1'b0;
        s00_axil_bvalid  = 1'b0;
        s00_axil_arready = 1'b0;
        s00_axil_rvalid  = 1'b0;

        case (state_q)
            IDLE: begin
                // A write is pending on awvalid alone; wvalid may trail.
                // On a tie the side not granted last time wins.
                if (s00_axil_awvalid && (!s00_axil_arvalid || !last_write_q)) begin
                    state_d      = WR_REQ;
                    last_write_d = 1'b1;
                    done_clear   = '1;
                end else if (s00_axil_arvalid) begin
                    state_d      = RD_ADDR;
                    last_write_d = 1'b0;
                end
            end
            RD_ADDR: begin
                m00_axil_arvalid = s00_axil_arvalid;
                s00_axil_arready = m00_axil_arready;
                if (s00_axil_arvalid && m00_axil_arready) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                s00_axil_rvalid = m00_axil_rvalid;
                m00_axil_rready = s00_axil_rready;
                if (m00_axil_rvalid && s00_axil_rready) begin
                    state_d = IDLE;
                end
            end
            WR_REQ: begin
                // Each channel is masked once it has transferred so a
                // beat is never presented downstream twice.
                aw_go            = s00_axil_awvalid & ~done_q[DONE_AW];
                w_go             = s00_axil_wvalid  & ~done_q[DONE_W];
                m00_axil_awvalid = aw_go;
                m00_axil_wvalid  = w_go;
                s00_axil_awready = m00_axil_awready & ~done_q[DONE_AW];
                s00_axil_wready  = m00_axil_wready  & ~done_q[DONE_W];
                aw_hs            = aw_go & m00_axil_awready;
                w_hs             = w_go  & m00_axil_wready;
                done_set[DONE_AW] = aw_hs;
                done_set[DONE_W]  = w_hs;
                if ((done_q[DONE_AW] || aw_hs) && (done_q[DONE_W] || w_hs)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                s00_axil_bvalid = m00_axil_bvalid;
                m00_axil_bready = s00_axil_bready;
                if (m00_axil_bvalid && s00_axil_bready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // last_write resets to 1 so that the first read/write tie goes to read.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            last_write_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_write_q <= last_write_d;
        end
    end

endmodule

// File: tb/tb_bsg_axil_rw_serializer.sv
// Self-checking bench for bsg_axil_rw_serializer.
//
// Upstream read/write requesters and a downstream AXI-Lite responder are
// modelled here. Issued requests push expected downstream beats and
// expected upstream responses into queues; a monitor pops and compares
// on every handshake, and also tracks arbitration order and the
// one-outstanding rule.
module tb_bsg_axil_rw_serializer;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 1000;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] s00_axil_awaddr = '0, s00_axil_araddr = '0;
    logic [2:0]    s00_axil_awprot = '0, s00_axil_arprot = '0;
    logic          s00_axil_awvalid = 1'b0, s00_axil_wvalid = 1'b0, s00_axil_arvalid = 1'b0;
    logic [DW-1:0] s00_axil_wdata = '0;
    logic [SW-1:0] s00_axil_wstrb = '0;
    logic          s00_axil_bready = 1'b0, s00_axil_rready = 1'b0;
    logic          s00_axil_awready, s00_axil_wready, s00_axil_arready;
    logic [1:0]    s00_axil_bresp, s00_axil_rresp;
    logic          s00_axil_bvalid, s00_axil_rvalid;
    logic [DW-1:0] s00_axil_rdata;

    logic [AW-1:0] m00_axil_awaddr, m00_axil_araddr;
    logic [2:0]    m00_axil_awprot, m00_axil_arprot;
    logic          m00_axil_awvalid, m00_axil_wvalid, m00_axil_arvalid;
    logic [DW-1:0] m00_axil_wdata;
    logic [SW-1:0] m00_axil_wstrb;
    logic          m00_axil_bready, m00_axil_rready;
    logic          m00_axil_awready, m00_axil_wready, m00_axil_arready;
    logic [1:0]    m00_axil_bresp, m00_axil_rresp;
    logic          m00_axil_bvalid, m00_axil_rvalid;
    logic [DW-1:0] m00_axil_rdata;

    bsg_axil_rw_serializer #(.addr_width_p(AW), .data_width_p(DW)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .s00_axil_awaddr  (s00_axil_awaddr),
        .s00_axil_awprot  (s00_axil_awprot),
        .s00_axil_awvalid (s00_axil_awvalid),
        .s00_axil_awready (s00_axil_awready),
        .s00_axil_wdata   (s00_axil_wdata),
        .s00_axil_wstrb   (s00_axil_wstrb),
        .s00_axil_wvalid  (s00_axil_wvalid),
        .s00_axil_wready  (s00_axil_wready),
        .s00_axil_bresp   (s00_axil_bresp),
        .s00_axil_bvalid  (s00_axil_bvalid),
        .s00_axil_bready  (s00_axil_bready),
        .s00_axil_araddr  (s00_axil_araddr),
        .s00_axil_arprot  (s00_axil_arprot),
        .s00_axil_arvalid (s00_axil_arvalid),
        .s00_axil_arready (s00_axil_arready),
        .s00_axil_rdata   (s00_axil_rdata),
        .s00_axil_rresp   (s00_axil_rresp),
        .s00_axil_rvalid  (s00_axil_rvalid),
        .s00_axil_rready  (s00_axil_rready),
        .m00_axil_awaddr  (m00_axil_awaddr),
        .m00_axil_awprot  (m00_axil_awprot),
        .m00_axil_awvalid (m00_axil_awvalid),
        .m00_axil_awready (m00_axil_awready),
        .m00_axil_wdata   (m00_axil_wdata),
        .m00_axil_wstrb   (m00_axil_wstrb),
        .m00_axil_wvalid  (m00_axil_wvalid),
        .m00_axil_wready  (m00_axil_wready),
        .m00_axil_bresp   (m00_axil_bresp),
        .m00_axil_bvalid  (m00_axil_bvalid),
        .m00_axil_bready  (m00_axil_bready),
        .m00_axil_araddr  (m00_axil_araddr),
        .m00_axil_arprot  (m00_axil_arprot),
        .m00_axil_arvalid (m00_axil_arvalid),
        .m00_axil_arready (m00_axil_arready),
        .m00_axil_rdata   (m00_axil_rdata),
        .m00_axil_rresp   (m00_axil_rresp),
        .m00_axil_rvalid  (m00_axil_rvalid),
        .m00_axil_rready  (m00_axil_rready)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Downstream responder content: read data/resp is a fixed function of
    // the address, write resp a fixed function of address, data and strobe.
    function automatic logic [33:0] rd_model(input logic [AW-1:0] a);
        logic [31:0] d;
        d = (a * 32'h9E3779B1) ^ 32'hA5A5_0F0F;
        return {a[3:2], d};
    endfunction

    function automatic logic [1:0] wr_model(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                            input logic [SW-1:0] s);
        return a[5:4] ^ d[1:0] ^ s[1:0];
    endfunction

    // Scoreboard queues
    logic [34:0] exp_ar_q[$];   // {prot, addr}
    logic [34:0] exp_aw_q[$];   // {prot, addr}
    logic [35:0] exp_w_q[$];    // {strb, data}
    logic [33:0] exp_r_q[$];    // {resp, data}
    logic [1:0]  exp_b_q[$];

    bit slave_rand = 1'b0;
    bit rand_ready = 1'b0;
    bit hold_ready = 1'b0;
    bit chk_alt    = 1'b0;
    bit prev_kind  = 1'b1;      // 1 = last grant was a write
    int outstanding = 0;

    // ---------------- downstream responder ----------------
    bit            sl_rst, sl_ar_hs, sl_r_hs, sl_aw_hs, sl_w_hs, sl_b_hs;
    bit            sl_rd_pend, sl_aw_got, sl_w_got;
    int            sl_rd_dly, sl_wr_dly;
    logic [AW-1:0] sl_ar_addr, sl_aw_addr, cap_ar, cap_aw;
    logic [DW-1:0] sl_w_data, cap_wd;
    logic [SW-1:0] sl_w_strb, cap_ws;
    logic [33:0]   sl_rd;

    initial begin
        m00_axil_awready = 1'b0; m00_axil_wready = 1'b0; m00_axil_arready = 1'b0;
        m00_axil_bvalid  = 1'b0; m00_axil_bresp  = '0;
        m00_axil_rvalid  = 1'b0; m00_axil_rdata  = '0;  m00_axil_rresp = '0;
        sl_rd_pend = 1'b0; sl_aw_got = 1'b0; sl_w_got = 1'b0;
        sl_rd_dly = 0; sl_wr_dly = 0;
        sl_ar_addr = '0; sl_aw_addr = '0; sl_w_data = '0; sl_w_strb = '0;
        forever begin
            @(negedge clk);
            sl_rst   = reset_i;
            sl_ar_hs = m00_axil_arvalid && m00_axil_arready;  cap_ar = m00_axil_araddr;
            sl_r_hs  = m00_axil_rvalid  && m00_axil_rready;
            sl_aw_hs = m00_axil_awvalid && m00_axil_awready;  cap_aw = m00_axil_awaddr;
            sl_w_hs  = m00_axil_wvalid  && m00_axil_wready;
            cap_wd   = m00_axil_wdata;  cap_ws = m00_axil_wstrb;
            sl_b_hs  = m00_axil_bvalid  && m00_axil_bready;
            @(posedge clk);
            #1;
            if (sl_rst) begin
                sl_rd_pend = 1'b0; sl_aw_got = 1'b0; sl_w_got = 1'b0;
                m00_axil_rvalid = 1'b0; m00_axil_bvalid = 1'b0;
                m00_axil_arready = 1'b0; m00_axil_awready = 1'b0; m00_axil_wready = 1'b0;
            end else begin
                if (sl_ar_hs) begin
                    sl_rd_pend = 1'b1;
                    sl_ar_addr = cap_ar;
                    sl_rd_dly  = slave_rand ? int'($urandom_range(0, 3)) : 0;
                end
                if (sl_r_hs) m00_axil_rvalid = 1'b0;
                if (sl_rd_pend) begin
                    if (sl_rd_dly == 0) begin
                        sl_rd = rd_model(sl_ar_addr);
                        m00_axil_rvalid = 1'b1;
                        m00_axil_rdata  = sl_rd[31:0];
                        m00_axil_rresp  = sl_rd[33:32];
                        sl_rd_pend = 1'b0;
                    end else begin
                        sl_rd_dly--;
                    end
                end
                if (sl_aw_hs) begin
                    sl_aw_got  = 1'b1;
                    sl_aw_addr = cap_aw;
                    sl_wr_dly  = slave_rand ? int'($urandom_range(0, 3)) : 0;
                end
                if (sl_w_hs) begin
                    sl_w_got  = 1'b1;
                    sl_w_data = cap_wd;
                    sl_w_strb = cap_ws;
                end
                if (sl_b_hs) m00_axil_bvalid = 1'b0;
                if (sl_aw_got && sl_w_got) begin
                    if (sl_wr_dly == 0) begin
                        m00_axil_bvalid = 1'b1;
                        m00_axil_bresp  = wr_model(sl_aw_addr, sl_w_data, sl_w_strb);
                        sl_aw_got = 1'b0;
                        sl_w_got  = 1'b0;
                    end else begin
                        sl_wr_dly--;
                    end
                end
                m00_axil_arready = slave_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                m00_axil_awready = slave_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                m00_axil_wready  = slave_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // ---------------- upstream response readiness ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold_ready) begin
                s00_axil_rready = 1'b0;
                s00_axil_bready = 1'b0;
            end else if (rand_ready) begin
                s00_axil_rready = 1'($urandom_range(0, 1));
                s00_axil_bready = 1'($urandom_range(0, 1));
            end else begin
                s00_axil_rready = 1'b1;
                s00_axil_bready = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [34:0] e35;
        logic [35:0] e36;
        logic [33:0] e34;
        logic [1:0]  e2;
        forever begin
            @(negedge clk);
            if (!reset_i) begin
                if (m00_axil_arvalid || m00_axil_awvalid)
                    check("ar_aw_mutex", 64'(m00_axil_arvalid & m00_axil_awvalid), 64'(0));
                if (m00_axil_arvalid && m00_axil_arready) begin
                    check("one_outstanding_rd", 64'(outstanding), 64'(0));
                    outstanding++;
                    if (chk_alt) check("alternation_rd_after_wr", 64'(prev_kind), 64'(1));
                    prev_kind = 1'b0;
                    check("ar_expected", 64'(exp_ar_q.size() != 0), 64'(1));
                    if (exp_ar_q.size() != 0) begin
                        e35 = exp_ar_q.pop_front();
                        check("m00_ar_prot_addr", 64'({m00_axil_arprot, m00_axil_araddr}), 64'(e35));
                    end
                end
                if (m00_axil_awvalid && m00_axil_awready) begin
                    check("one_outstanding_wr", 64'(outstanding), 64'(0));
                    outstanding++;
                    if (chk_alt) check("alternation_wr_after_rd", 64'(prev_kind), 64'(0));
                    prev_kind = 1'b1;
                    check("aw_expected", 64'(exp_aw_q.size() != 0), 64'(1));
                    if (exp_aw_q.size() != 0) begin
                        e35 = exp_aw_q.pop_front();
                        check("m00_aw_prot_addr", 64'({m00_axil_awprot, m00_axil_awaddr}), 64'(e35));
                    end
                end
                if (m00_axil_wvalid && m00_axil_wready) begin
                    check("w_expected", 64'(exp_w_q.size() != 0), 64'(1));
                    if (exp_w_q.size() != 0) begin
                        e36 = exp_w_q.pop_front();
                        check("m00_w_strb_data", 64'({m00_axil_wstrb, m00_axil_wdata}), 64'(e36));
                    end
                end
                if (s00_axil_rvalid && s00_axil_rready) begin
                    outstanding--;
                    check("r_expected", 64'(exp_r_q.size() != 0), 64'(1));
                    if (exp_r_q.size() != 0) begin
                        e34 = exp_r_q.pop_front();
                        check("s00_r_resp_data", 64'({s00_axil_rresp, s00_axil_rdata}), 64'(e34));
                    end
                end
                if (s00_axil_bvalid && s00_axil_bready) begin
                    outstanding--;
                    check("b_expected", 64'(exp_b_q.size() != 0), 64'(1));
                    if (exp_b_q.size() != 0) begin
                        e2 = exp_b_q.pop_front();
                        check("s00_bresp", 64'(s00_axil_bresp), 64'(e2));
                    end
                end
            end
        end
    end

    // ---------------- upstream requesters ----------------
    task automatic run_reads(input int n, input int gmax);
        logic [AW-1:0] a;
        logic [2:0]    p;
        bit            hs;
        int            t;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gmax)) begin
                @(posedge clk);
                #1;
            end
            a = AW'($urandom);
            p = 3'($urandom_range(0, 7));
            s00_axil_araddr  = a;
            s00_axil_arprot  = p;
            s00_axil_arvalid = 1'b1;
            exp_ar_q.push_back({p, a});
            exp_r_q.push_back(rd_model(a));
            hs = 1'b0;
            t  = 0;
            while (!hs && t < TMO) begin
                @(negedge clk);
                hs = s00_axil_arvalid && s00_axil_arready;
                t++;
            end
            @(posedge clk);
            #1;
            s00_axil_arvalid = 1'b0;
            if (!hs) begin
                check("ar_handshake_timeout", 64'(hs), 64'(1));
                return;
            end
        end
    endtask

    task automatic run_writes(input int n, input int gmax, input int wdmax);
        logic [AW-1:0] a;
        logic [2:0]    p;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        bit            hs_aw, hs_w;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gmax)) begin
                @(posedge clk);
                #1;
            end
            a = AW'($urandom);
            p = 3'($urandom_range(0, 7));
            d = DW'($urandom);
            s = SW'($urandom_range(0, (1 << SW) - 1));
            exp_aw_q.push_back({p, a});
            exp_w_q.push_back({s, d});
            exp_b_q.push_back(wr_model(a, d, s));
            hs_aw = 1'b0;
            hs_w  = 1'b0;
            fork
                begin
                    int t;
                    t = 0;
                    s00_axil_awaddr  = a;
                    s00_axil_awprot  = p;
                    s00_axil_awvalid = 1'b1;
                    while (!hs_aw && t < TMO) begin
                        @(negedge clk);
                        hs_aw = s00_axil_awvalid && s00_axil_awready;
                        t++;
                    end
                    @(posedge clk);
                    #1;
                    s00_axil_awvalid = 1'b0;
                end
                begin
                    int t;
                    t = 0;
                    repeat ($urandom_range(0, wdmax)) begin
                        @(posedge clk);
                        #1;
                    end
                    s00_axil_wdata  = d;
                    s00_axil_wstrb  = s;
                    s00_axil_wvalid = 1'b1;
                    while (!hs_w && t < TMO) begin
                        @(negedge clk);
                        hs_w = s00_axil_wvalid && s00_axil_wready;
                        t++;
                    end
                    @(posedge clk);
                    #1;
                    s00_axil_wvalid = 1'b0;
                end
            join
            if (!(hs_aw && hs_w)) begin
                check("aw_w_handshake_timeout", 64'({hs_aw, hs_w}), 64'(3));
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_i          = 1'b1;
        s00_axil_arvalid = 1'b0;
        s00_axil_awvalid = 1'b0;
        s00_axil_wvalid  = 1'b0;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        exp_ar_q.delete(); exp_aw_q.delete(); exp_w_q.delete();
        exp_r_q.delete();  exp_b_q.delete();
        outstanding = 0;
        @(negedge clk);
        check("reset_valid_ready_outputs",
              64'({s00_axil_awready, s00_axil_wready, s00_axil_bvalid, s00_axil_arready,
                   s00_axil_rvalid, m00_axil_awvalid, m00_axil_wvalid, m00_axil_bready,
                   m00_axil_arvalid, m00_axil_rready}), 64'(0));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_ar_q.size() + exp_aw_q.size() + exp_w_q.size() +
                exp_r_q.size() + exp_b_q.size()) != 0 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check("scoreboard_drained",
              64'(exp_ar_q.size() + exp_aw_q.size() + exp_w_q.size() +
                  exp_r_q.size() + exp_b_q.size()), 64'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit hs;
        int t;

        // Directed single read: grant one cycle after the request is seen
        // in IDLE, response forwarded in the same cycle it arrives.
        slave_rand = 1'b0;
        rand_ready = 1'b0;
        do_reset();
        @(posedge clk);
        #1;
        s00_axil_araddr  = 32'h40;
        s00_axil_arprot  = 3'd0;
        s00_axil_arvalid = 1'b1;
        exp_ar_q.push_back({3'd0, 32'h40});
        exp_r_q.push_back(rd_model(32'h40));
        @(negedge clk);
        check("idle_no_m00_arvalid", 64'(m00_axil_arvalid), 64'(0));
        @(negedge clk);
        check("grant_latency_m00_arvalid", 64'(m00_axil_arvalid), 64'(1));
        check("arready_passthrough", 64'(s00_axil_arready), 64'(1));
        @(posedge clk);
        #1;
        s00_axil_arvalid = 1'b0;
        @(negedge clk);
        check("rvalid_zero_latency", 64'(s00_axil_rvalid), 64'(1));
        @(negedge clk);
        check("back_to_idle", 64'({m00_axil_arvalid, s00_axil_rvalid, m00_axil_rready}), 64'(0));
        drain();

        // Continuous streams from reset: strict read/write alternation,
        // starting with read.
        do_reset();
        slave_rand = 1'b1;
        rand_ready = 1'b0;
        prev_kind  = 1'b1;
        chk_alt    = 1'b1;
        fork
            run_reads(100, 0);
            run_writes(100, 0, 0);
        join
        drain();
        chk_alt = 1'b0;

        // Random gaps, late write data, random back-pressure everywhere.
        rand_ready = 1'b1;
        fork
            run_reads(60, 4);
            run_writes(60, 4, 5);
        join
        drain();

        // Reset while a read response is waiting upstream.
        rand_ready = 1'b0;
        slave_rand = 1'b0;
        hold_ready = 1'b1;
        @(posedge clk);
        #1;
        s00_axil_araddr  = 32'h80;
        s00_axil_arprot  = 3'd1;
        s00_axil_arvalid = 1'b1;
        exp_ar_q.push_back({3'd1, 32'h80});
        exp_r_q.push_back(rd_model(32'h80));
        hs = 1'b0;
        t  = 0;
        while (!hs && t < 50) begin
            @(negedge clk);
            hs = s00_axil_rvalid;
            t++;
            if (s00_axil_arvalid && s00_axil_arready) begin
                @(posedge clk);
                #1;
                s00_axil_arvalid = 1'b0;
            end
        end
        check("rvalid_pending_before_reset", 64'(hs), 64'(1));
        do_reset();
        hold_ready = 1'b0;
        run_reads(1, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks, %0d errors", n_checks, n_err);
        $fatal(1, "watchdog");
    end

endmodule
